// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W data bits LSB first,
// optional even parity (define SERIAL_TX_PARITY_EN), stop bit; each bit lasts CLKS_PER_BIT clocks.
module serial_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    output logic              ready,
    output logic              busy,
    output logic              tx,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end_c;

    assign bit_end_c = (baud_q == BAUD_LAST);

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        done_d  = 1'b0;
        tx_d    = 1'b1;

        if (state_q != ST_IDLE) begin
            baud_d = bit_end_c ? '0 : baud_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                idx_d  = '0;
                if (load) begin
                    shift_d = data;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^data;
`endif
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end_c) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_c) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end_c) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = !ready_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4); frames are hand-written bit vectors,
// bit j being the j-th bit on the line. Define SERIAL_TX_PARITY_EN for the parity build.
module tb_serial_tx;

    localparam int unsigned C = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned NB = 11;
    localparam logic [10:0] FR_A5 = 11'b10101001010;
    localparam logic [10:0] FR_FF = 11'b10111111110;
    localparam logic [10:0] FR_81 = 11'b10100000010;
    localparam logic [10:0] FR_07 = 11'b11000001110;
`else
    localparam int unsigned NB = 10;
    localparam logic [10:0] FR_A5 = 11'b01101001010;
    localparam logic [10:0] FR_FF = 11'b01111111110;
    localparam logic [10:0] FR_81 = 11'b01100000010;
    localparam logic [10:0] FR_07 = 11'b01000001110;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       load;
    logic       ready, busy, tx, done;

    int n_cmp = 0;
    int n_err = 0;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .load  (load),
        .ready (ready),
        .busy  (busy),
        .tx    (tx),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, then presents d with load for one edge; returns in cycle 1.
    task automatic send(input logic [7:0] d);
        int guard = 0;
        while (ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        check("ready_wait", 32'(guard < 200), 32'd1);
        data = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Starting in cycle 1, checks every cycle of the frame; ends in cycle NB*C+1 (the done cycle).
    // With hold set, load=1/data=FF is driven from cycle 2 onward and left asserted.
    task automatic check_frame(input string tag, input logic [10:0] exp_frame, input bit hold);
        int k;
        for (int j = 0; j < int'(NB); j++) begin
            for (int c = 0; c < int'(C); c++) begin
                k = j * int'(C) + c + 1;
                if (hold && k == 2) begin
                    data = 8'hFF;
                    load = 1'b1;
                end
                check({tag, "_tx"}, 32'(tx), 32'(exp_frame[j]));
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_ready"}, 32'(ready), 32'd0);
                check({tag, "_done"}, 32'(done), 32'd0);
                tick();
            end
        end
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_done_ready"}, 32'(ready), 32'd1);
        check({tag, "_done_tx"}, 32'(tx), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        data  = 8'h00;
        load  = 1'b0;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Idle: line high, ready, never done.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_tx", 32'(tx), 32'd1);
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end

        // Single A5 frame, done exactly in cycle 41, then a single-cycle pulse.
        send(8'hA5);
        check_frame("a5", FR_A5, 1'b0);
        tick();
        check("a5_done_once", 32'(done), 32'd0);
        check("a5_idle_tx", 32'(tx), 32'd1);

        // A5 with FF held on the input mid-frame; FF taken at the done cycle, start bit next cycle.
        send(8'hA5);
        check_frame("a5_hold", FR_A5, 1'b1);
        tick();
        load = 1'b0;
        check_frame("ff_b2b", FR_FF, 1'b0);
        tick();

        // Reset in cycle 15 of a 3C frame; outputs recover asynchronously.
        send(8'h3C);
        for (int k = 1; k < 15; k++) tick();
        check("3c_pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        send(8'h81);
        check_frame("81", FR_81, 1'b0);
        tick();

        // 07: three ones, so odd data weight (parity bit 1 in the parity build).
        send(8'h07);
        check_frame("07", FR_07, 1'b0);
        tick();
        check("end_tx", 32'(tx), 32'd1);
        check("end_ready", 32'(ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
